// File: rtl/ex_complete_ctrl_pkg.sv
// Shared execute-stage types: tags, issue/remove packets, functional-unit
// select, memory FSM states and the execute slot record.
`ifndef MUL_LAT
`define MUL_LAT 4
`endif

package ex_complete_ctrl_pkg;

  localparam int MUL_LAT_DEF = `MUL_LAT;
  localparam int RS_IDX_BITS = 3;
  localparam int PHYS_REG_W  = 6;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } ALU_FUNC;

  typedef struct packed {
    logic [PHYS_REG_W-1:0] phys_reg;
  } TAG;

  typedef struct packed {
    logic    valid;
    TAG      t;
    logic    rd_mem;
    logic    wr_mem;
    ALU_FUNC alu_func;
  } DECODER_PACKET;

  typedef struct packed {
    logic                   issue_en;
    logic [RS_IDX_BITS-1:0] rs_idx;
    DECODER_PACKET          decoder_packet;
  } RS_IS_PACKET;

  typedef struct packed {
    logic                   remove_en;
    logic [RS_IDX_BITS-1:0] remove_idx;
  } EX_RS_PACKET;

  typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_MEM} FU_SEL;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} MEM_STATE;

  typedef struct packed {
    logic                   valid;
    TAG                     t;
    logic [RS_IDX_BITS-1:0] rs_idx;
    logic                   is_store;
  } EX_SLOT;

  // Memory ops take priority over the multiply decode.
  function automatic FU_SEL fu_select(input DECODER_PACKET d);
    FU_SEL sel;
    sel = FU_ALU;
    if (d.rd_mem || d.wr_mem) begin
      sel = FU_MEM;
    end else begin
      case (d.alu_func)
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: sel = FU_MUL;
        default:                                 sel = FU_ALU;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_complete_ctrl_if.sv
// Issue / completion / memory-request bundle between the reservation
// station side and the execute completion controller.
interface ex_complete_ctrl_if
  import ex_complete_ctrl_pkg::*;
#(
  parameter int RS_IDX_W = RS_IDX_BITS
);

  RS_IS_PACKET         rs_is_packet;
  logic                mem_grant;
  logic                mem_done;
  logic                is_stall;
  TAG                  cdb;
  logic                cdb_en;
  EX_RS_PACKET         ex_rs_packet;
  logic                mem_req;
  logic                mem_req_wr;
  logic [RS_IDX_W-1:0] mem_req_rs_idx;
  logic [2:0]          ex_busy_status;

  modport master (
    input  rs_is_packet, mem_grant, mem_done,
    output is_stall, cdb, cdb_en, ex_rs_packet,
           mem_req, mem_req_wr, mem_req_rs_idx, ex_busy_status
  );

  modport slave (
    output rs_is_packet, mem_grant, mem_done,
    input  is_stall, cdb, cdb_en, ex_rs_packet,
           mem_req, mem_req_wr, mem_req_rs_idx, ex_busy_status
  );

endinterface

// File: rtl/ex_complete_ctrl_mul.sv
// Stallable multiplier tracking pipe: MUL_LAT stages of valid/tag/rs_idx.
// The whole pipe moves together; it freezes only when the last stage holds
// an entry that lost completion arbitration.
module ex_mul_pipe
  import ex_complete_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   capture,
  input  TAG                     in_t,
  input  logic [RS_IDX_BITS-1:0] in_rs_idx,
  input  logic                   complete,
  output logic                   accept,
  output EX_SLOT                 last,
  output logic                   busy
);

  localparam int LAST = MUL_LAT - 1;

  logic [MUL_LAT-1:0]     vld_p;
  TAG                     tag_p [MUL_LAT];
  logic [RS_IDX_BITS-1:0] idx_p [MUL_LAT];
  logic                   advance;

  assign advance = !vld_p[LAST] || complete;
  // A stalled pipe can still take an entry into an empty first stage.
  assign accept  = advance || !vld_p[0];
  assign busy    = |vld_p;
  assign last    = '{valid: vld_p[LAST], t: tag_p[LAST], rs_idx: idx_p[LAST], is_store: 1'b0};

  // Stage valids: shift on advance, otherwise only fill an empty stage 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p <= {vld_p[MUL_LAT-2:0], capture};
    end else if (capture) begin
      vld_p[0] <= 1'b1;
    end
  end

  // Stage payload follows the valids; no reset needed on data.
  always_ff @(posedge clock) begin
    if (advance) begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        tag_p[i] <= tag_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
    end
    if (capture) begin
      tag_p[0] <= in_t;
      idx_p[0] <= in_rs_idx;
    end
  end

endmodule

// File: rtl/ex_complete_ctrl.sv
// Execute-side completion controller: routes issued instructions to the
// ALU slot, multiplier pipe or memory FSM, back-pressures issue, and picks
// one completion per cycle for the CDB and the RS remove port.
module ex_complete_ctrl
  import ex_complete_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int RS_IDX_W = RS_IDX_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               interrupt,
  ex_complete_ctrl_if.master bus
);

  DECODER_PACKET          dec;
  logic                   issue_vld;
  FU_SEL                  fu_sel;
  logic                   unit_accept;
  logic                   capture;
  logic                   alu_cap;
  logic                   mul_cap;
  logic                   mem_cap;
  logic                   alu_accept;
  logic                   mul_accept;
  logic                   mul_busy;

  logic                   alu_vld_p0;
  TAG                     alu_tag_p0;
  logic [RS_IDX_BITS-1:0] alu_idx_p0;

  MEM_STATE               mem_state;
  TAG                     mem_tag;
  logic [RS_IDX_W-1:0]    mem_idx;
  logic                   mem_wr;

  EX_SLOT                 alu_view;
  EX_SLOT                 mul_view;
  EX_SLOT                 mem_view;
  EX_SLOT                 win;
  FU_SEL                  win_src;
  logic                   alu_win;
  logic                   mul_win;
  logic                   mem_win;

  assign dec       = bus.rs_is_packet.decoder_packet;
  assign issue_vld = bus.rs_is_packet.issue_en && dec.valid;
  assign fu_sel    = fu_select(dec);

  assign alu_accept = !alu_vld_p0 || alu_win;

  // Target-unit acceptance for the current issue.
  always_comb begin
    unit_accept = 1'b0;
    case (fu_sel)
      FU_ALU:  unit_accept = alu_accept;
      FU_MUL:  unit_accept = mul_accept;
      FU_MEM:  unit_accept = (mem_state == IDLE);
      default: unit_accept = 1'b0;
    endcase
  end

  assign bus.is_stall = (issue_vld && !unit_accept) || interrupt;
  assign capture      = issue_vld && !bus.is_stall;
  assign alu_cap      = capture && (fu_sel == FU_ALU);
  assign mul_cap      = capture && (fu_sel == FU_MUL);
  assign mem_cap      = capture && (fu_sel == FU_MEM);

  // ALU slot occupancy: a new capture overrides a same-cycle completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_vld_p0 <= 1'b0;
    end else if (interrupt) begin
      alu_vld_p0 <= 1'b0;
    end else if (alu_cap) begin
      alu_vld_p0 <= 1'b1;
    end else if (alu_win) begin
      alu_vld_p0 <= 1'b0;
    end
  end

  // ALU slot payload.
  always_ff @(posedge clock) begin
    if (alu_cap) begin
      alu_tag_p0 <= dec.t;
      alu_idx_p0 <= bus.rs_is_packet.rs_idx;
    end
  end

  ex_mul_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_pipe (
    .clock     (clock),
    .reset     (reset),
    .flush     (interrupt),
    .capture   (mul_cap),
    .in_t      (dec.t),
    .in_rs_idx (bus.rs_is_packet.rs_idx),
    .complete  (mul_win),
    .accept    (mul_accept),
    .last      (mul_view),
    .busy      (mul_busy)
  );

  // Memory FSM: one outstanding request; an interrupted request that was
  // already granted drains until memory reports done, silently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_state <= IDLE;
    end else begin
      case (mem_state)
        IDLE: begin
          if (mem_cap) mem_state <= REQ;
        end
        REQ: begin
          if (interrupt)                          mem_state <= IDLE;
          else if (bus.mem_grant && bus.mem_done) mem_state <= DONE;
          else if (bus.mem_grant)                 mem_state <= WAIT;
        end
        WAIT: begin
          if (interrupt)         mem_state <= bus.mem_done ? IDLE : DRAIN;
          else if (bus.mem_done) mem_state <= DONE;
        end
        DONE: begin
          if (interrupt || mem_win) mem_state <= IDLE;
        end
        DRAIN: begin
          if (bus.mem_done) mem_state <= IDLE;
        end
        default: mem_state <= IDLE;
      endcase
    end
  end

  // Memory request payload, held stable from capture until completion.
  always_ff @(posedge clock) begin
    if (mem_cap) begin
      mem_tag <= dec.t;
      mem_idx <= RS_IDX_W'(bus.rs_is_packet.rs_idx);
      mem_wr  <= dec.wr_mem;
    end
  end

  assign alu_view = '{valid: alu_vld_p0, t: alu_tag_p0, rs_idx: alu_idx_p0, is_store: 1'b0};
  assign mem_view = '{valid: (mem_state == DONE), t: mem_tag,
                      rs_idx: RS_IDX_BITS'(mem_idx), is_store: mem_wr};

  // Fixed-priority completion pick: MEM > MUL > ALU; interrupt kills it.
  always_comb begin
    win     = '0;
    win_src = FU_ALU;
    if (mem_view.valid) begin
      win     = mem_view;
      win_src = FU_MEM;
    end else if (mul_view.valid) begin
      win     = mul_view;
      win_src = FU_MUL;
    end else if (alu_view.valid) begin
      win     = alu_view;
      win_src = FU_ALU;
    end
    if (interrupt) win.valid = 1'b0;
  end

  assign alu_win = win.valid && (win_src == FU_ALU);
  assign mul_win = win.valid && (win_src == FU_MUL);
  assign mem_win = win.valid && (win_src == FU_MEM);

  assign bus.cdb_en       = win.valid && !win.is_store;
  assign bus.cdb          = bus.cdb_en ? win.t : '0;
  assign bus.ex_rs_packet = '{remove_en: win.valid, remove_idx: (win.valid ? win.rs_idx : '0)};

  assign bus.mem_req        = (mem_state == REQ);
  assign bus.mem_req_wr     = bus.mem_req && mem_wr;
  assign bus.mem_req_rs_idx = bus.mem_req ? mem_idx : '0;
  assign bus.ex_busy_status = {(mem_state != IDLE), mul_busy, alu_vld_p0};

endmodule

// File: tb/tb_ex_complete_ctrl.sv
// Directed bench for ex_complete_ctrl: a vector table for ALU/MUL issue and
// arbitration, then hand sequences for memory, interrupt and reset cases.
module tb_ex_complete_ctrl;
  import ex_complete_ctrl_pkg::*;

  logic clock;
  logic reset;
  logic interrupt;
  int   errors;
  int   checks;

  ex_complete_ctrl_if bus ();

  ex_complete_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .interrupt (interrupt),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic       en;
    logic       vld;
    logic [2:0] idx;
    logic [5:0] tag;
    ALU_FUNC    f;
    logic       x_stall;
    logic       x_cdb_en;
    logic [5:0] x_cdb;
    logic       x_rm;
    logic [2:0] x_idx;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  function automatic vec_t mk(input int en, input int vld, input int idx, input int tag,
                              input ALU_FUNC f, input int xs, input int xc, input int xcdb,
                              input int xr, input int xi);
    vec_t v;
    v.en = 1'(en);       v.vld = 1'(vld);      v.idx = 3'(idx);   v.tag = 6'(tag);
    v.f = f;             v.x_stall = 1'(xs);   v.x_cdb_en = 1'(xc);
    v.x_cdb = 6'(xcdb);  v.x_rm = 1'(xr);      v.x_idx = 3'(xi);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic xs, input logic xc, input logic [5:0] xcdb,
                         input logic xr, input logic [2:0] xi);
    chk({n, ".is_stall"},   32'(bus.is_stall), 32'(xs));
    chk({n, ".cdb_en"},     32'(bus.cdb_en), 32'(xc));
    chk({n, ".cdb"},        32'(bus.cdb.phys_reg), 32'(xcdb));
    chk({n, ".remove_en"},  32'(bus.ex_rs_packet.remove_en), 32'(xr));
    chk({n, ".remove_idx"}, 32'(bus.ex_rs_packet.remove_idx), 32'(xi));
  endtask

  task automatic drive_issue(input logic vld, input logic [2:0] idx, input logic [5:0] tag,
                             input logic rd, input logic wr, input ALU_FUNC f);
    RS_IS_PACKET p;
    p = '0;
    p.issue_en                       = 1'b1;
    p.rs_idx                         = idx;
    p.decoder_packet.valid           = vld;
    p.decoder_packet.t.phys_reg      = tag;
    p.decoder_packet.rd_mem          = rd;
    p.decoder_packet.wr_mem          = wr;
    p.decoder_packet.alu_func        = f;
    bus.rs_is_packet = p;
  endtask

  task automatic idle_issue();
    bus.rs_is_packet = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    interrupt = 1'b0;
    bus.mem_grant = 1'b0;
    bus.mem_done  = 1'b0;
    idle_issue();

    vt[0]  = mk(1, 1, 0, 12, ALU_ADD,   0, 0,  0, 0, 0);
    vt[1]  = mk(1, 1, 1, 13, ALU_SUB,   0, 1, 12, 1, 0);
    vt[2]  = mk(1, 1, 3, 20, ALU_MUL,   0, 1, 13, 1, 1);
    vt[3]  = mk(0, 0, 0,  0, ALU_ADD,   0, 0,  0, 0, 0);
    vt[4]  = mk(0, 0, 0,  0, ALU_ADD,   0, 0,  0, 0, 0);
    vt[5]  = mk(1, 1, 4,  5, ALU_XOR,   0, 0,  0, 0, 0);
    vt[6]  = mk(1, 1, 5,  6, ALU_OR,    1, 1, 20, 1, 3);
    vt[7]  = mk(0, 0, 0,  0, ALU_ADD,   0, 1,  5, 1, 4);
    vt[8]  = mk(1, 0, 6, 30, ALU_ADD,   0, 0,  0, 0, 0);
    vt[9]  = mk(1, 1, 1, 21, ALU_MULH,  0, 0,  0, 0, 0);
    vt[10] = mk(1, 1, 2, 22, ALU_MULHU, 0, 0,  0, 0, 0);
    vt[11] = mk(0, 0, 0,  0, ALU_ADD,   0, 0,  0, 0, 0);
    vt[12] = mk(0, 0, 0,  0, ALU_ADD,   0, 0,  0, 0, 0);
    vt[13] = mk(0, 0, 0,  0, ALU_ADD,   0, 1, 21, 1, 1);
    vt[14] = mk(0, 0, 0,  0, ALU_ADD,   0, 1, 22, 1, 2);
    vt[15] = mk(0, 0, 0,  0, ALU_ADD,   0, 0,  0, 0, 0);

    // Reset state
    #3;
    chk_out("reset", 1'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk("reset.mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset.busy", 32'(bus.ex_busy_status), 32'd0);
    next_cycle();
    reset = 1'b1;

    // ALU / MUL vector table
    for (int i = 0; i < NV; i++) begin
      if (vt[i].en) drive_issue(vt[i].vld, vt[i].idx, vt[i].tag, 1'b0, 1'b0, vt[i].f);
      else          idle_issue();
      settle();
      chk_out($sformatf("vec%0d", i), vt[i].x_stall, vt[i].x_cdb_en, vt[i].x_cdb,
              vt[i].x_rm, vt[i].x_idx);
      next_cycle();
    end
    idle_issue();

    // Load with delayed grant/done; MUL arrives on the DONE cycle and loses
    drive_issue(1'b1, 3'd2, 6'd7, 1'b1, 1'b0, ALU_ADD);
    settle(); chk("ld0.stall", 32'(bus.is_stall), 32'd0); chk("ld0.req", 32'(bus.mem_req), 32'd0);
    next_cycle(); idle_issue();
    settle(); chk("ld1.req", 32'(bus.mem_req), 32'd1); chk("ld1.wr", 32'(bus.mem_req_wr), 32'd0);
    chk("ld1.idx", 32'(bus.mem_req_rs_idx), 32'd2); chk("ld1.busy", 32'(bus.ex_busy_status), 32'd4);
    next_cycle();
    settle(); chk("ld2.req", 32'(bus.mem_req), 32'd1); chk("ld2.idx", 32'(bus.mem_req_rs_idx), 32'd2);
    next_cycle(); bus.mem_grant = 1'b1; drive_issue(1'b1, 3'd6, 6'd26, 1'b0, 1'b0, ALU_MULHSU);
    settle(); chk("ld3.req", 32'(bus.mem_req), 32'd1); chk("ld3.mulstall", 32'(bus.is_stall), 32'd0);
    next_cycle(); bus.mem_grant = 1'b0; drive_issue(1'b1, 3'd4, 6'd8, 1'b1, 1'b0, ALU_ADD);
    settle(); chk("ld4.stall", 32'(bus.is_stall), 32'd1); chk("ld4.req", 32'(bus.mem_req), 32'd0);
    next_cycle(); idle_issue();
    settle(); chk("ld5.cdb_en", 32'(bus.cdb_en), 32'd0);
    next_cycle(); bus.mem_done = 1'b1;
    settle(); chk("ld6.cdb_en", 32'(bus.cdb_en), 32'd0);
    next_cycle(); bus.mem_done = 1'b0;
    settle(); chk_out("ld7", 1'b0, 1'b1, 6'd7, 1'b1, 3'd2);
    next_cycle();
    settle(); chk_out("ld8", 1'b0, 1'b1, 6'd26, 1'b1, 3'd6);
    next_cycle();
    settle(); chk_out("ld9", 1'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk("ld9.busy", 32'(bus.ex_busy_status), 32'd0);
    next_cycle();

    // Store with grant and done in the same REQ cycle
    drive_issue(1'b1, 3'd1, 6'd9, 1'b0, 1'b1, ALU_ADD);
    settle(); chk("st0.stall", 32'(bus.is_stall), 32'd0);
    next_cycle(); idle_issue(); bus.mem_grant = 1'b1; bus.mem_done = 1'b1;
    settle(); chk("st1.req", 32'(bus.mem_req), 32'd1); chk("st1.wr", 32'(bus.mem_req_wr), 32'd1);
    chk("st1.idx", 32'(bus.mem_req_rs_idx), 32'd1);
    next_cycle(); bus.mem_grant = 1'b0; bus.mem_done = 1'b0;
    settle(); chk_out("st2", 1'b0, 1'b0, 6'd0, 1'b1, 3'd1);
    next_cycle();
    settle(); chk_out("st3", 1'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk("st3.busy", 32'(bus.ex_busy_status), 32'd0);
    next_cycle();

    // Interrupt in REQ drops the request and kills an ALU completion
    drive_issue(1'b1, 3'd2, 6'd2, 1'b1, 1'b0, ALU_ADD);
    next_cycle(); drive_issue(1'b1, 3'd0, 6'd1, 1'b0, 1'b0, ALU_AND);
    settle(); chk("rq1.stall", 32'(bus.is_stall), 32'd0);
    next_cycle(); idle_issue(); interrupt = 1'b1;
    settle(); chk_out("rq2", 1'b1, 1'b0, 6'd0, 1'b0, 3'd0);
    next_cycle(); interrupt = 1'b0;
    settle(); chk_out("rq3", 1'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk("rq3.busy", 32'(bus.ex_busy_status), 32'd0); chk("rq3.req", 32'(bus.mem_req), 32'd0);
    next_cycle();

    // Interrupt in WAIT with a MUL in flight -> DRAIN, nothing reported
    drive_issue(1'b1, 3'd2, 6'd7, 1'b1, 1'b0, ALU_ADD);
    next_cycle(); bus.mem_grant = 1'b1; drive_issue(1'b1, 3'd5, 6'd25, 1'b0, 1'b0, ALU_MUL);
    settle(); chk("ir1.stall", 32'(bus.is_stall), 32'd0);
    next_cycle(); bus.mem_grant = 1'b0; interrupt = 1'b1; drive_issue(1'b1, 3'd0, 6'd3, 1'b0, 1'b0, ALU_ADD);
    settle(); chk("ir2.busy", 32'(bus.ex_busy_status), 32'd6);
    chk_out("ir2", 1'b1, 1'b0, 6'd0, 1'b0, 3'd0);
    next_cycle(); interrupt = 1'b0; idle_issue();
    for (int k = 3; k < 9; k++) begin
      settle();
      chk($sformatf("ir%0d.cdb_en", k), 32'(bus.cdb_en), 32'd0);
      chk($sformatf("ir%0d.remove_en", k), 32'(bus.ex_rs_packet.remove_en), 32'd0);
      chk($sformatf("ir%0d.req", k), 32'(bus.mem_req), 32'd0);
      chk($sformatf("ir%0d.busy", k), 32'(bus.ex_busy_status), 32'd4);
      next_cycle();
    end
    bus.mem_done = 1'b1;
    settle(); chk_out("ir9", 1'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    next_cycle(); bus.mem_done = 1'b0; drive_issue(1'b1, 3'd3, 6'd11, 1'b0, 1'b0, ALU_ADD);
    settle(); chk("ir10.busy", 32'(bus.ex_busy_status), 32'd0); chk("ir10.stall", 32'(bus.is_stall), 32'd0);
    next_cycle(); idle_issue();
    settle(); chk_out("ir11", 1'b0, 1'b1, 6'd11, 1'b1, 3'd3);
    next_cycle();

    // Async reset with a MUL in flight and memory in REQ
    drive_issue(1'b1, 3'd1, 6'd14, 1'b0, 1'b0, ALU_MUL);
    next_cycle(); drive_issue(1'b1, 3'd2, 6'd15, 1'b1, 1'b0, ALU_ADD);
    next_cycle(); idle_issue();
    settle(); chk("rs0.busy", 32'(bus.ex_busy_status), 32'd6); chk("rs0.req", 32'(bus.mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk_out("rs1", 1'b0, 1'b0, 6'd0, 1'b0, 3'd0);
    chk("rs1.req", 32'(bus.mem_req), 32'd0);
    chk("rs1.idx", 32'(bus.mem_req_rs_idx), 32'd0);
    chk("rs1.busy", 32'(bus.ex_busy_status), 32'd0);
    next_cycle(); reset = 1'b1; drive_issue(1'b1, 3'd4, 6'd16, 1'b0, 1'b0, ALU_SLT);
    settle(); chk("rs2.busy", 32'(bus.ex_busy_status), 32'd0); chk("rs2.stall", 32'(bus.is_stall), 32'd0);
    next_cycle(); idle_issue();
    settle(); chk_out("rs3", 1'b0, 1'b1, 6'd16, 1'b1, 3'd4);
    next_cycle();
    for (int k = 4; k < 9; k++) begin
      settle();
      chk($sformatf("rs%0d.cdb_en", k), 32'(bus.cdb_en), 32'd0);
      chk($sformatf("rs%0d.req", k), 32'(bus.mem_req), 32'd0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
